// File: rtl/fifo_state_ctrl_pkg.sv
// Shared definitions for the FIFO pointer/occupancy controller:
// default depth and the 2-bit controller state encoding.
package fifo_state_ctrl_pkg;

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'b00,
    ST_PARTIAL = 2'b01,
    ST_FULL    = 2'b10,
    ST_ERR     = 2'b11
  } fifo_state_e;

endpackage

// File: rtl/fifo_state_ctrl_ptr_counter.sv
// Wrap-around pointer counter. Advances by one on each enabled edge and
// wraps naturally at 2**W, which matches a power-of-two FIFO depth.
module ptr_counter
  import fifo_state_ctrl_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] value
);

  // Pointer register; cleared asynchronously, steps on enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (en) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_state_ctrl.sv
// Pointer/occupancy controller for the FIFO register file. Generates the
// write/read pointers and write enable, tracks occupancy, and decodes the
// full/empty/valid flags plus a sticky error on overflow or underflow.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_EMPTY   | count == 0, nothing to read
//   ST_PARTIAL | 0 < count < DEPTH
//   ST_FULL    | count == DEPTH, push only allowed together with a pop
//   ST_ERR     | overflow/underflow seen; frozen until reset
module fifo_state_ctrl
  import fifo_state_ctrl_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in_valid,
  input  logic             pop_fifo,
  output logic [PTR_W-1:0] write_ptr,
  output logic [PTR_W-1:0] read_ptr,
  output logic             wr_en,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             data_out_valid,
  output logic [PTR_W:0]   count,
  output logic             err
);

  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  fifo_state_e    state;
  logic [PTR_W:0] count_nxt;
  logic           st_err;
  logic           underflow;
  logic           overflow;
  logic           push_ok;
  logic           pop_ok;

  assign st_err         = (state == ST_ERR);
  assign fifo_empty     = (count == '0);
  assign fifo_full      = (count == DEPTH_CNT);
  assign data_out_valid = !fifo_empty && !st_err;
  assign err            = st_err;

  // A pop on an empty FIFO is an underflow even if a push arrives in the
  // same cycle: the pushed word is dropped rather than bypassed.
  assign underflow = pop_fifo && fifo_empty && !st_err;
  assign overflow  = data_in_valid && fifo_full && !pop_fifo && !st_err;

  assign push_ok = data_in_valid && !st_err && (!fifo_full || pop_fifo) && !underflow;
  assign pop_ok  = pop_fifo && !st_err && !fifo_empty;

  // The register file writes on wr_en, so keep it quiet while in reset.
  assign wr_en = push_ok && rst;

  assign count_nxt = count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop_ok};

  ptr_counter #(.W(PTR_W)) u_write_ptr (
    .clk   (clk),
    .rst   (rst),
    .en    (push_ok),
    .value (write_ptr)
  );

  ptr_counter #(.W(PTR_W)) u_read_ptr (
    .clk   (clk),
    .rst   (rst),
    .en    (pop_ok),
    .value (read_ptr)
  );

  // Occupancy register and controller state; ERR holds everything frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_EMPTY;
      count <= '0;
    end else begin
      count <= count_nxt;
      case (state)
        ST_EMPTY: begin
          if (underflow) begin
            state <= ST_ERR;
          end else if (push_ok) begin
            state <= ST_PARTIAL;
          end
        end
        ST_PARTIAL: begin
          if (count_nxt == '0) begin
            state <= ST_EMPTY;
          end else if (count_nxt == DEPTH_CNT) begin
            state <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (overflow) begin
            state <= ST_ERR;
          end else if (pop_ok && !push_ok) begin
            state <= ST_PARTIAL;
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state <= ST_ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_state_ctrl.sv
// Directed bench for fifo_state_ctrl. The stimulus process applies one
// vector per cycle and queues the outputs expected during that cycle; a
// monitor pops each entry at the falling edge and compares.
module tb_fifo_state_ctrl;

  logic       clk;
  logic       rst;
  logic       data_in_valid;
  logic       pop_fifo;
  logic [1:0] write_ptr;
  logic [1:0] read_ptr;
  logic       wr_en;
  logic       fifo_full;
  logic       fifo_empty;
  logic       data_out_valid;
  logic [2:0] count;
  logic       err;

  typedef struct {
    int idx;
    int wp;
    int rp;
    int cnt;
    int we;
    int full;
    int empty;
    int dov;
    int er;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   vec_n = 0;

  fifo_state_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_valid  (data_in_valid),
    .pop_fifo       (pop_fifo),
    .write_ptr      (write_ptr),
    .read_ptr       (read_ptr),
    .wr_en          (wr_en),
    .fifo_full      (fifo_full),
    .fifo_empty     (fifo_empty),
    .data_out_valid (data_out_valid),
    .count          (count),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, act, expv);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic step(input logic r, input logic psh, input logic pp,
                      input int wp, input int rp, input int cnt, input int we,
                      input int fu, input int em, input int dv, input int er);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    data_in_valid = psh;
    pop_fifo      = pp;
    e.idx = vec_n; e.wp = wp; e.rp = rp; e.cnt = cnt; e.we = we;
    e.full = fu; e.empty = em; e.dov = dv; e.er = er;
    sb.push_back(e);
    vec_n++;
  endtask

  // Monitor: compare all outputs mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("write_ptr",      e.idx, int'(write_ptr),      e.wp);
        chk("read_ptr",       e.idx, int'(read_ptr),       e.rp);
        chk("count",          e.idx, int'(count),          e.cnt);
        chk("wr_en",          e.idx, int'(wr_en),          e.we);
        chk("fifo_full",      e.idx, int'(fifo_full),      e.full);
        chk("fifo_empty",     e.idx, int'(fifo_empty),     e.empty);
        chk("data_out_valid", e.idx, int'(data_out_valid), e.dov);
        chk("err",            e.idx, int'(err),            e.er);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b0;
    data_in_valid = 1'b0;
    pop_fifo      = 1'b0;

    //   rst psh pop  wp rp cnt we full empty dov err
    // held in reset with a push pending: wr_en must stay low
    step(0, 1, 0,   0, 0, 0,  0, 0,   1,    0,  0);
    // fill
    step(1, 1, 0,   0, 0, 0,  1, 0,   1,    0,  0);
    step(1, 1, 0,   1, 0, 1,  1, 0,   0,    1,  0);
    step(1, 1, 0,   2, 0, 2,  1, 0,   0,    1,  0);
    step(1, 1, 0,   3, 0, 3,  1, 0,   0,    1,  0);
    // full after 4th push; drain
    step(1, 0, 1,   0, 0, 4,  0, 1,   0,    1,  0);
    step(1, 0, 1,   0, 1, 3,  0, 0,   0,    1,  0);
    step(1, 0, 1,   0, 2, 2,  0, 0,   0,    1,  0);
    step(1, 0, 1,   0, 3, 1,  0, 0,   0,    1,  0);
    step(1, 0, 0,   0, 0, 0,  0, 0,   1,    0,  0);
    // refill to 2, push+pop at count 2
    step(1, 1, 0,   0, 0, 0,  1, 0,   1,    0,  0);
    step(1, 1, 0,   1, 0, 1,  1, 0,   0,    1,  0);
    step(1, 1, 1,   2, 0, 2,  1, 0,   0,    1,  0);
    step(1, 1, 0,   3, 1, 2,  1, 0,   0,    1,  0);
    step(1, 1, 0,   0, 1, 3,  1, 0,   0,    1,  0);
    // push+pop at full
    step(1, 1, 1,   1, 1, 4,  1, 1,   0,    1,  0);
    step(1, 0, 0,   2, 2, 4,  0, 1,   0,    1,  0);
    // overflow, then frozen
    step(1, 1, 0,   2, 2, 4,  0, 1,   0,    1,  0);
    step(1, 1, 1,   2, 2, 4,  0, 1,   0,    0,  1);
    step(1, 0, 1,   2, 2, 4,  0, 1,   0,    0,  1);
    // only reset clears err
    step(0, 0, 0,   0, 0, 0,  0, 0,   1,    0,  0);
    step(1, 0, 0,   0, 0, 0,  0, 0,   1,    0,  0);
    // underflow with a push in the same cycle
    step(1, 1, 1,   0, 0, 0,  0, 0,   1,    0,  0);
    step(1, 1, 0,   0, 0, 0,  0, 0,   1,    0,  1);
    step(0, 0, 0,   0, 0, 0,  0, 0,   1,    0,  0);
    // async reset mid-stream at count 3, checked before the next edge
    step(1, 1, 0,   0, 0, 0,  1, 0,   1,    0,  0);
    step(1, 1, 0,   1, 0, 1,  1, 0,   0,    1,  0);
    step(1, 1, 0,   2, 0, 2,  1, 0,   0,    1,  0);
    step(0, 1, 0,   0, 0, 0,  0, 0,   1,    0,  0);
    step(1, 0, 0,   0, 0, 0,  0, 0,   1,    0,  0);
    // wrap: 9 push/pop pairs keep the pointers equal modulo 4
    for (int i = 0; i < 9; i++) begin
      step(1, 1, 0, i % 4,       i % 4, 0, 1, 0, 1, 0, 0);
      step(1, 0, 1, (i + 1) % 4, i % 4, 1, 0, 0, 0, 1, 0);
    end
    step(1, 0, 0,   1, 1, 0,  0, 0,   1,    0,  0);

    repeat (2) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
